ars_route: RTL and testbench
============================

Name: ars_route

Overview:
- Registered 1-to-2 demultiplexer for 233-bit GF(2^233) field words.
- Takes one word per handshake from the datapath result bus and steers it into destination slot A (SEL=1) or slot B (SEL=0). Each slot holds one word until its consumer takes it.
- Sits on the write-back side of the point-arithmetic datapath and feeds the operand pair that the ARS_SELECT mux chooses between.
- Signals PAIR_VALID when both operands are loaded.

Parameters:
- W, 233, field word width (degree m of sect233 polynomial basis).
- CW, 8, width of accepted-word counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- CLEAR  input  1  synchronous flush of both slots.
- IN_VALID  input  1  producer has a word on DIN.
- IN_READY  output  1  selected slot can accept this cycle.
- SEL  input  1  destination: 1 = slot A, 0 = slot B; qualified by IN_VALID.
- DIN  input  W  field word in.
- A_OUT  output  W  slot A contents.
- A_VALID  output  1  slot A full.
- A_READY  input  1  consumer takes slot A.
- B_OUT  output  W  slot B contents.
- B_VALID  output  1  slot B full.
- B_READY  input  1  consumer takes slot B.
- PAIR_VALID  output  1  A_VALID & B_VALID.
- ACC_CNT  output  CW  count of accepted words, modulo 2^CW.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: A_VALID=0, B_VALID=0, A_OUT=0, B_OUT=0, ACC_CNT=0, PAIR_VALID=0.
  - IN_READY is 0 while RST=1.
  - RST asserted mid-operation discards both slots on the next edge; nothing is held over.
- Accept condition: acc = IN_VALID & IN_READY & !CLEAR & !RST.
- Ready function (combinational):
  - IN_READY = !RST & !CLEAR & (SEL ? (!A_VALID | A_READY) : (!B_VALID | B_READY)).
  - IN_READY depends on SEL and the destination consumer's ready. No dependence on IN_VALID.
- Latency: word accepted at edge k appears on the slot's OUT with VALID=1 after edge k. One-cycle latency, no bypass from DIN to OUT.
- Slot update rules (per slot X in {A,B}), CLEAR low:
  - Write (acc with SEL selecting X): X_OUT<=DIN, X_VALID<=1.
  - Consume only (X_VALID & X_READY, no write): X_VALID<=0. X_OUT holds its old value.
  - Write and consume in the same cycle: the new word replaces the old one, X_VALID stays 1. This gives full throughput of one word per cycle per slot.
  - X_READY while X_VALID=0: ignored.
- Non-selected slot is unaffected by a write: data and valid hold, its own consume still applies.
- CLEAR=1: both VALIDs <=0 next edge; OUT data registers hold. No accept, so ACC_CNT holds. Consumer READY is ignored that cycle.
- PAIR_VALID is combinational AND of registered valids, so it is glitch-free relative to CLK.
- ACC_CNT increments by 1 on every acc. It wraps from 2^CW-1 to 0 with no flag.
- Full slot with no consumer ready: IN_READY=0 for that SEL. The producer must hold IN_VALID, SEL and DIN stable until accept.
  - A bench assertion flags a SEL or DIN change while IN_VALID=1 and IN_READY=0.
- X_OUT is stable whenever X_VALID=1 and no write occurs.
- X bits are never propagated: data registers reset to 0.

Decomposition:
- Shared package ars_pkg:
  - constant FIELD_M=233, word type field_word_t [FIELD_M-1:0].
  - The same constant is used by ARS_SELECT and the arithmetic units.
- One sub-module ars_slot: single-entry register with valid/ready, write-enable, consume and clear. Instantiated twice.
  - Its write-enables are acc&SEL and acc&!SEL.
- ars_route holds only the ready mux, the counter and PAIR_VALID.

Test Plan:
- Reset: RST=1 for 2 cycles with IN_VALID=1 -> IN_READY=0, A_VALID=B_VALID=0, ACC_CNT=0, A_OUT=B_OUT=0.
- Steering:
  - SEL=1, DIN=233'h1_0000...00AB accepted at edge k -> A_OUT=that word, A_VALID=1 after edge k, B unchanged.
  - SEL=0, DIN=233'h0FF accepted at edge k+1 -> B_VALID=1, PAIR_VALID=1 after edge k+1, ACC_CNT=2.
- Backpressure: A full, A_READY=0, IN_VALID=1, SEL=1 -> IN_READY=0 for 5 cycles and A_OUT holds. Switching the test to SEL=0 with B empty -> IN_READY=1.
- Simultaneous refill: A holds 0x5, A_READY=1, SEL=1, DIN=0x6 same cycle -> A_VALID stays 1, A_OUT=0x6, ACC_CNT+1. Streaming 10 words back-to-back gives 10 accepts in 10 cycles.
- CLEAR: both slots full, CLEAR=1 with IN_VALID=1 -> IN_READY=0, both VALIDs=0 next cycle, ACC_CNT unchanged.
- Wrap and mid-operation reset: 256 accepts -> ACC_CNT=0. RST pulsed while A full and IN_VALID=1 -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/ars_pkg.sv
// Shared field-word definitions for the sect233 point-arithmetic datapath.
// FIELD_M is the polynomial-basis degree used by routing, select and arithmetic units.
package ars_pkg;
   localparam int FIELD_M = 233;
   typedef logic [FIELD_M-1:0] field_word_t;
endpackage

// File: rtl/ars_slot.sv
// Single-entry holding register with valid/ready hand-off, write-enable and flush.
// A write in the same cycle as a consume replaces the word, so the slot sustains one word per cycle.
module ars_slot
   import ars_pkg::*;
#(
   parameter int W = FIELD_M
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         wr_en,
   input  logic [W-1:0] din,
   input  logic         rdy,
   output logic [W-1:0] dout,
   output logic         vld
);

   logic [W-1:0] data_p1;
   logic         vld_p1;

   // Stage p1: slot register; clr drops valid only, data is kept
   always_ff @(posedge clk) begin
      if (rst) begin
         data_p1 <= '0;
         vld_p1  <= 1'b0;
      end else if (clr) begin
         vld_p1  <= 1'b0;
      end else if (wr_en) begin
         data_p1 <= din;
         vld_p1  <= 1'b1;
      end else if (vld_p1 && rdy) begin
         vld_p1  <= 1'b0;
      end
   end

   assign dout = data_p1;
   assign vld  = vld_p1;

endmodule

// File: rtl/ars_route.sv
// Registered 1-to-2 demux steering result-bus field words into operand slots A and B.
// Holds the per-destination ready mux, the accepted-word counter and the pair-valid flag.
module ars_route
   import ars_pkg::*;
#(
   parameter int W  = FIELD_M,
   parameter int CW = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CLEAR,
   input  logic          IN_VALID,
   output logic          IN_READY,
   input  logic          SEL,
   input  logic [W-1:0]  DIN,
   output logic [W-1:0]  A_OUT,
   output logic          A_VALID,
   input  logic          A_READY,
   output logic [W-1:0]  B_OUT,
   output logic          B_VALID,
   input  logic          B_READY,
   output logic          PAIR_VALID,
   output logic [CW-1:0] ACC_CNT
);

   logic          acc;
   logic          a_vld;
   logic          b_vld;
   logic [CW-1:0] cnt_p1;

   // Ready follows only the addressed slot, so a stalled A never blocks a B write
   assign IN_READY = !RST && !CLEAR && (SEL ? (!a_vld || A_READY) : (!b_vld || B_READY));
   assign acc      = IN_VALID && IN_READY;

   ars_slot #(.W(W)) u_slot_a (
      .clk   (CLK),
      .rst   (RST),
      .clr   (CLEAR),
      .wr_en (acc && SEL),
      .din   (DIN),
      .rdy   (A_READY),
      .dout  (A_OUT),
      .vld   (a_vld)
   );

   ars_slot #(.W(W)) u_slot_b (
      .clk   (CLK),
      .rst   (RST),
      .clr   (CLEAR),
      .wr_en (acc && !SEL),
      .din   (DIN),
      .rdy   (B_READY),
      .dout  (B_OUT),
      .vld   (b_vld)
   );

   // Stage p1: accepted-word counter, wraps silently
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_p1 <= '0;
      end else if (acc) begin
         cnt_p1 <= cnt_p1 + {{(CW-1){1'b0}}, 1'b1};
      end
   end

   assign ACC_CNT    = cnt_p1;
   assign A_VALID    = a_vld;
   assign B_VALID    = b_vld;
   assign PAIR_VALID = a_vld && b_vld;

endmodule

// File: tb/tb_ars_route.sv
// Bench for ars_route: vector table with hand-derived expectations, per-slot scoreboard
// queues, multi-cycle streaming/wrap/reset sequences and a producer hold-stable check.
module tb_ars_route;
   import ars_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        CLEAR = 1'b0;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic        SEL = 1'b0;
   field_word_t DIN = '0;
   field_word_t A_OUT;
   logic        A_VALID;
   logic        A_READY = 1'b0;
   field_word_t B_OUT;
   logic        B_VALID;
   logic        B_READY = 1'b0;
   logic        PAIR_VALID;
   logic [7:0]  ACC_CNT;

   ars_route #(.W(FIELD_M), .CW(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .CLEAR      (CLEAR),
      .IN_VALID   (IN_VALID),
      .IN_READY   (IN_READY),
      .SEL        (SEL),
      .DIN        (DIN),
      .A_OUT      (A_OUT),
      .A_VALID    (A_VALID),
      .A_READY    (A_READY),
      .B_OUT      (B_OUT),
      .B_VALID    (B_VALID),
      .B_READY    (B_READY),
      .PAIR_VALID (PAIR_VALID),
      .ACC_CNT    (ACC_CNT)
   );

   always #5 CLK = ~CLK;

   int n_cmp  = 0;
   int n_fail = 0;

   // Bench-side slot state and scoreboard queues
   logic        mav = 1'b0;
   logic        mbv = 1'b0;
   logic [7:0]  mcnt = 8'd0;
   field_word_t qa[$];
   field_word_t qb[$];

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chkw(input string name, input field_word_t act, input field_word_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: drive at negedge, check ready and consumed words before the edge,
   // then check registered state against the bench model after the edge.
   task automatic cyc(input logic rst, input logic clr, input logic iv, input logic sel,
                      input field_word_t din, input logic ar, input logic br,
                      output logic rdy);
      logic exp_rdy;
      logic acc;
      @(negedge CLK);
      RST = rst; CLEAR = clr; IN_VALID = iv; SEL = sel; DIN = din;
      A_READY = ar; B_READY = br;
      #1;
      rdy     = IN_READY;
      exp_rdy = !rst && !clr && (sel ? (!mav || ar) : (!mbv || br));
      acc     = iv && exp_rdy;
      chk1("in_ready_model", rdy, exp_rdy);
      if (rst || clr) begin
         qa.delete();
         qb.delete();
         mav = 1'b0;
         mbv = 1'b0;
         if (rst) mcnt = 8'd0;
      end else begin
         if (mav && ar) begin
            chkw("a_pop", A_OUT, qa.pop_front());
            mav = 1'b0;
         end
         if (mbv && br) begin
            chkw("b_pop", B_OUT, qb.pop_front());
            mbv = 1'b0;
         end
         if (acc && sel) begin
            qa.push_back(din);
            mav = 1'b1;
         end
         if (acc && !sel) begin
            qb.push_back(din);
            mbv = 1'b1;
         end
         if (acc) mcnt = mcnt + 8'd1;
      end
      @(posedge CLK);
      #1;
      chk1("a_valid_model", A_VALID, mav);
      chk1("b_valid_model", B_VALID, mbv);
      chk1("pair_valid_model", PAIR_VALID, mav && mbv);
      chk8("acc_cnt_model", ACC_CNT, mcnt);
   endtask

   // Producer must hold SEL/DIN while a valid word is stalled
   logic        p_stall = 1'b0;
   logic        p_sel = 1'b0;
   field_word_t p_din = '0;
   always begin
      @(negedge CLK);
      #3;
      if (p_stall && IN_VALID) begin
         n_cmp++;
         if (SEL !== p_sel || DIN !== p_din) begin
            n_fail++;
            $display("FAIL hold_stable: sel %b din %h expected sel %b din %h", SEL, DIN, p_sel, p_din);
         end
      end
      p_stall <= IN_VALID && !IN_READY && !RST && !CLEAR;
      p_sel   <= SEL;
      p_din   <= DIN;
   end

   typedef struct {
      logic        rst, clr, iv, sel;
      field_word_t din;
      logic        ar, br;
      logic        e_rdy, e_av, e_bv, e_pv;
      logic [7:0]  e_cnt;
      field_word_t e_a, e_b;
   } vec_t;

   function automatic vec_t mk(input logic rst, clr, iv, sel, input field_word_t din,
                               input logic ar, br, e_rdy, e_av, e_bv, e_pv,
                               input logic [7:0] e_cnt, input field_word_t e_a, e_b);
      vec_t v;
      v.rst = rst; v.clr = clr; v.iv = iv; v.sel = sel; v.din = din;
      v.ar = ar; v.br = br; v.e_rdy = e_rdy; v.e_av = e_av; v.e_bv = e_bv;
      v.e_pv = e_pv; v.e_cnt = e_cnt; v.e_a = e_a; v.e_b = e_b;
      return v;
   endfunction

   vec_t tbl[16];

   initial begin
      field_word_t wa, z, h123, hff, w5, w6, w7, w8;
      logic rdy;
      int nacc;

      wa   = (field_word_t'(1) << (FIELD_M - 1)) | field_word_t'(8'hAB);
      z    = '0;
      h123 = field_word_t'(12'h123);
      hff  = field_word_t'(8'hFF);
      w5   = field_word_t'(4'h5);
      w6   = field_word_t'(4'h6);
      w7   = field_word_t'(4'h7);
      w8   = field_word_t'(4'h8);

      //            rst clr iv sel din   ar br  rdy av bv pv cnt  aout bout
      tbl[0]  = mk(1, 0, 1, 1, wa,   0, 0,  0, 0, 0, 0, 8'd0, z,  z);
      tbl[1]  = mk(1, 0, 1, 1, wa,   0, 0,  0, 0, 0, 0, 8'd0, z,  z);
      tbl[2]  = mk(0, 0, 1, 1, wa,   0, 0,  1, 1, 0, 0, 8'd1, wa, z);
      for (int i = 3; i <= 7; i++)
         tbl[i] = mk(0, 0, 1, 1, h123, 0, 0, 0, 1, 0, 0, 8'd1, wa, z);
      tbl[8]  = mk(0, 0, 0, 0, hff,  0, 0,  1, 1, 0, 0, 8'd1, wa, z);
      tbl[9]  = mk(0, 0, 1, 0, hff,  0, 0,  1, 1, 1, 1, 8'd2, wa, hff);
      tbl[10] = mk(0, 0, 0, 0, hff,  1, 1,  1, 0, 0, 0, 8'd2, wa, hff);
      tbl[11] = mk(0, 0, 1, 1, w5,   0, 0,  1, 1, 0, 0, 8'd3, w5, hff);
      tbl[12] = mk(0, 0, 1, 1, w6,   1, 0,  1, 1, 0, 0, 8'd4, w6, hff);
      tbl[13] = mk(0, 0, 1, 0, w7,   0, 0,  1, 1, 1, 1, 8'd5, w6, w7);
      tbl[14] = mk(0, 1, 1, 1, w8,   1, 1,  0, 0, 0, 0, 8'd5, w6, w7);
      tbl[15] = mk(0, 0, 0, 1, w8,   1, 1,  1, 0, 0, 0, 8'd5, w6, w7);

      foreach (tbl[i]) begin
         cyc(tbl[i].rst, tbl[i].clr, tbl[i].iv, tbl[i].sel, tbl[i].din,
             tbl[i].ar, tbl[i].br, rdy);
         chk1($sformatf("v%0d_in_ready", i), rdy, tbl[i].e_rdy);
         chk1($sformatf("v%0d_a_valid", i), A_VALID, tbl[i].e_av);
         chk1($sformatf("v%0d_b_valid", i), B_VALID, tbl[i].e_bv);
         chk1($sformatf("v%0d_pair_valid", i), PAIR_VALID, tbl[i].e_pv);
         chk8($sformatf("v%0d_acc_cnt", i), ACC_CNT, tbl[i].e_cnt);
         chkw($sformatf("v%0d_a_out", i), A_OUT, tbl[i].e_a);
         chkw($sformatf("v%0d_b_out", i), B_OUT, tbl[i].e_b);
      end

      // Back-to-back streaming into A with the consumer always ready
      nacc = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 1, 1, field_word_t'(100 + i), 1, 0, rdy);
         if (rdy) nacc++;
      end
      n_cmp++;
      if (nacc != 10) begin
         n_fail++;
         $display("FAIL stream_accepts: got %0d expected 10", nacc);
      end
      chkw("stream_last_a", A_OUT, field_word_t'(109));
      chk8("stream_cnt", ACC_CNT, 8'd15);
      cyc(0, 0, 0, 1, z, 1, 0, rdy);

      // Counter wrap: 256 accepts from reset return to zero
      cyc(1, 0, 0, 0, z, 0, 0, rdy);
      for (int i = 0; i < 256; i++)
         cyc(0, 0, 1, 0, field_word_t'(i), 0, 1, rdy);
      chk8("wrap_cnt", ACC_CNT, 8'd0);
      chkw("wrap_last_b", B_OUT, field_word_t'(255));
      cyc(0, 0, 0, 0, z, 0, 1, rdy);

      // Mid-operation reset with A full and a stalled producer
      cyc(0, 0, 1, 1, wa, 0, 0, rdy);
      cyc(0, 0, 1, 1, h123, 0, 0, rdy);
      chk1("stall_ready", rdy, 1'b0);
      cyc(1, 0, 1, 1, h123, 0, 0, rdy);
      chk1("rst_in_ready", rdy, 1'b0);
      chk1("rst_a_valid", A_VALID, 1'b0);
      chk1("rst_b_valid", B_VALID, 1'b0);
      chk1("rst_pair_valid", PAIR_VALID, 1'b0);
      chkw("rst_a_out", A_OUT, z);
      chkw("rst_b_out", B_OUT, z);
      chk8("rst_cnt", ACC_CNT, 8'd0);
      cyc(0, 0, 0, 1, z, 0, 0, rdy);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
